// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : gshare_predictor
//  Purpose  : Global-history (gshare) branch direction predictor. A table of
//             2-bit saturating counters is indexed with PC[GHR_WIDTH+1:2]
//             XOR the global history register. Produces a combinational
//             prediction for IF and a registered copy that travels with the
//             instruction into ID, where the resolved outcome trains the
//             table entry and the history register.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             if_pc             - PC of the instruction in IF
//             if_id_load        - IF/ID register load enable
//             if_id_flush       - IF/ID register flush
//             id_br_en          - resolved outcome of the ID branch
//             ghr_load          - shift id_br_en into the history
//             increment_pht     - train the ID entry toward taken
//             decrement_pht     - train the ID entry toward not-taken
//             if_br_pr          - IF prediction (combinational)
//             id_br_pr          - prediction carried into ID (registered)
//             id_pht_idx        - table index carried into ID
//  Revision : 1.0 - initial release
// ============================================================================
module gshare_predictor #(
    parameter int         GHR_WIDTH = 8,
    parameter logic [1:0] PHT_INIT  = 2'b01
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          if_pc,
    input  logic                 if_id_load,
    input  logic                 if_id_flush,
    input  logic                 id_br_en,
    input  logic                 ghr_load,
    input  logic                 increment_pht,
    input  logic                 decrement_pht,
    output logic                 if_br_pr,
    output logic                 id_br_pr,
    output logic [GHR_WIDTH-1:0] id_pht_idx
);

    localparam int         c_PHT_DEPTH = 2 ** GHR_WIDTH;
    localparam logic [1:0] c_CTR_MAX   = 2'b11;
    localparam logic [1:0] c_CTR_MIN   = 2'b00;

    logic [1:0]           r_pht [c_PHT_DEPTH];
    logic [GHR_WIDTH-1:0] r_ghr;
    logic [GHR_WIDTH-1:0] r_id_pht_idx;
    logic                 r_id_br_pr;

    logic [GHR_WIDTH-1:0] w_if_idx;
    logic [1:0]           w_id_ctr;
    logic [1:0]           w_id_ctr_next;
    logic                 w_train_en;
    logic                 w_unused;

    // Index uses the history as it stands before this edge's shift.
    assign w_if_idx = if_pc[GHR_WIDTH+1:2] ^ r_ghr;

    // Read-before-write: the table is only updated on the clock edge, so a
    // same-cycle training of this entry shows up one cycle later.
    assign if_br_pr = r_pht[w_if_idx][1];

    assign w_id_ctr = r_pht[r_id_pht_idx];

    // Saturating 2-bit update. Increment and decrement together cancel.
    always_comb begin
        w_id_ctr_next = w_id_ctr;
        w_train_en    = 1'b0;
        if (increment_pht && !decrement_pht && (w_id_ctr != c_CTR_MAX)) begin
            w_id_ctr_next = w_id_ctr + 2'd1;
            w_train_en    = if_id_load;
        end else if (decrement_pht && !increment_pht && (w_id_ctr != c_CTR_MIN)) begin
            w_id_ctr_next = w_id_ctr - 2'd1;
            w_train_en    = if_id_load;
        end
    end

    // Training is gated by if_id_load so a stalled ID branch trains once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_PHT_DEPTH; i++) begin
                r_pht[i] <= PHT_INIT;
            end
        end else if (w_train_en) begin
            r_pht[r_id_pht_idx] <= w_id_ctr_next;
        end
    end

    // History holds resolved outcomes only; it is never repaired on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (ghr_load) begin
            r_ghr <= {r_ghr[GHR_WIDTH-2:0], id_br_en};
        end
    end

    // IF/ID pipe copy: flush only takes effect together with load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id_pht_idx <= '0;
            r_id_br_pr   <= 1'b0;
        end else if (if_id_load) begin
            if (if_id_flush) begin
                r_id_pht_idx <= '0;
                r_id_br_pr   <= 1'b0;
            end else begin
                r_id_pht_idx <= w_if_idx;
                r_id_br_pr   <= if_br_pr;
            end
        end
    end

    assign id_pht_idx = r_id_pht_idx;
    assign id_br_pr   = r_id_br_pr;

    // PC bits outside the index field are intentionally ignored.
    assign w_unused = ^{if_pc[31:GHR_WIDTH+2], if_pc[1:0]};

endmodule
`default_nettype wire
